rob: RTL

ROB -- requirements
Module: rob

---
 rtl/rob.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/rob.sv
// Reorder buffer: circular array of in-flight entries with multi-lane dispatch,
// out-of-order completion, in-order head retirement and full flush on branch recovery.
package rob_pkg;
  localparam int PREG_BITS = 6;
  localparam int AREG_BITS = 5;
  localparam int XLEN      = 32;

  typedef struct packed {
    logic [PREG_BITS-1:0] t_idx;
    logic [PREG_BITS-1:0] told_idx;
    logic [AREG_BITS-1:0] ar_idx;
    logic [XLEN-1:0]      npc;
    logic                 halt;
  } dispatch_packet_t;

  typedef struct packed {
    logic [XLEN-1:0] dest_value;
    logic            precise_state_enable;
    logic [XLEN-1:0] target_pc;
  } complete_packet_t;

  typedef struct packed {
    logic                 complete;
    logic [XLEN-1:0]      dest_value;
    logic [PREG_BITS-1:0] t_idx;
    logic [PREG_BITS-1:0] told_idx;
    logic [AREG_BITS-1:0] ar_idx;
    logic [XLEN-1:0]      npc;
    logic                 halt;
    logic                 precise_state_enable;
    logic [XLEN-1:0]      target_pc;
  } rob_packet_t;
endpackage

module rob
  import rob_pkg::*;
#(
  parameter int ROB_SIZE         = 32,
  parameter int SUPERSCALAR_WAYS = 3,
  localparam int ROB_BITS        = $clog2(ROB_SIZE)
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [SUPERSCALAR_WAYS-1:0]                  dispatch_valid,
  input  dispatch_packet_t [SUPERSCALAR_WAYS-1:0]      dispatch_in,
  input  logic [SUPERSCALAR_WAYS-1:0]                  complete_valid,
  input  logic [SUPERSCALAR_WAYS-1:0][ROB_BITS-1:0]    complete_rob_idx,
  input  complete_packet_t [SUPERSCALAR_WAYS-1:0]      complete_in,
  input  logic [1:0]                                   retire_num,
  input  logic                                         br_recover_enable,
  output rob_packet_t [SUPERSCALAR_WAYS-1:0]           retire_rob_out,
  output logic [SUPERSCALAR_WAYS-1:0][ROB_BITS-1:0]    dispatch_rob_idx,
  output logic                                         dispatch_accept,
  output logic [ROB_BITS:0]                            free_slots
);

  localparam int CNT_W = ROB_BITS + 1;

  rob_packet_t                 entries [ROB_SIZE];
  logic [ROB_BITS-1:0]         head;
  logic [ROB_BITS-1:0]         tail;
  logic [CNT_W-1:0]            count;
  logic [CNT_W-1:0]            disp_k;
  logic [CNT_W-1:0]            ret_k;
  logic [ROB_BITS-1:0]         comp_off;
  logic [SUPERSCALAR_WAYS-1:0] comp_ok;

  function automatic rob_packet_t new_entry(input dispatch_packet_t d);
    rob_packet_t e;
    e                      = '0;
    e.t_idx                = d.t_idx;
    e.told_idx             = d.told_idx;
    e.ar_idx               = d.ar_idx;
    e.npc                  = d.npc;
    e.halt                 = d.halt;
    return e;
  endfunction

  always_comb begin
    disp_k = '0;
    for (int i = 0; i < SUPERSCALAR_WAYS; i++)
      disp_k = disp_k + CNT_W'(dispatch_valid[i]);
  end

  // Over-retire is a protocol error; clamping keeps count from underflowing.
  assign ret_k = (CNT_W'(retire_num) > count) ? count : CNT_W'(retire_num);

  assign free_slots      = CNT_W'(ROB_SIZE) - count;
  assign dispatch_accept = (disp_k <= free_slots) && !br_recover_enable;

  // A completion only lands on an entry that stays occupied after this cycle's retire.
  always_comb begin
    comp_ok  = '0;
    comp_off = '0;
    for (int j = 0; j < SUPERSCALAR_WAYS; j++) begin
      comp_off   = complete_rob_idx[j] - head;
      comp_ok[j] = complete_valid[j] &&
                   ({1'b0, comp_off} >= ret_k) &&
                   ({1'b0, comp_off} < count);
    end
  end

  always_comb begin
    for (int i = 0; i < SUPERSCALAR_WAYS; i++) begin
      dispatch_rob_idx[i] = tail + ROB_BITS'(i);
      if (CNT_W'(i) < count)
        retire_rob_out[i] = entries[head + ROB_BITS'(i)];
      else
        retire_rob_out[i] = '0;
    end
  end

  always_ff @(posedge clock) begin
    // Reset and branch recovery have the same effect; reset simply also covers it.
    if (reset || br_recover_enable) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int e = 0; e < ROB_SIZE; e++)
        entries[e] <= '0;
    end else begin
      for (int i = 0; i < SUPERSCALAR_WAYS; i++)
        if (CNT_W'(i) < ret_k)
          entries[head + ROB_BITS'(i)] <= '0;

      // Ascending lane order lets the highest lane win a duplicated index.
      for (int j = 0; j < SUPERSCALAR_WAYS; j++) begin
        if (comp_ok[j]) begin
          entries[complete_rob_idx[j]].complete             <= 1'b1;
          entries[complete_rob_idx[j]].dest_value           <= complete_in[j].dest_value;
          entries[complete_rob_idx[j]].precise_state_enable <= complete_in[j].precise_state_enable;
          entries[complete_rob_idx[j]].target_pc            <= complete_in[j].target_pc;
        end
      end

      if (dispatch_accept) begin
        for (int i = 0; i < SUPERSCALAR_WAYS; i++)
          if (dispatch_valid[i])
            entries[tail + ROB_BITS'(i)] <= new_entry(dispatch_in[i]);
        tail <= tail + ROB_BITS'(disp_k);
      end

      head  <= head + ROB_BITS'(ret_k);
      count <= count + (dispatch_accept ? disp_k : '0) - ret_k;
    end
  end

endmodule
